alarm_melody: RTL and testbench
===============================

// Module: alarm_melody
// PURPOSE
//  Consumer end of the alarm trigger: takes the alarm-match level `s` from the alarm block and drives the piezo with a looping melody.
//  Stops when the match minute ends, the alarm is disarmed, or the user presses STOP.
//  Sits between the alarm block and the board piezo pin; one instance per design.
// PARAMETERS
//  NOTE_TICKS  50000  CLK cycles a note sounds (tone phase)
//  GAP_TICKS   10000  CLK cycles of silence after each note
//  MEL_LEN     8      notes per melody loop (1..16); table lives in alarm_pkg
// PORTS
//  CLK        in   1  system clock, single clock domain
//  RESETN     in   1  asynchronous, active-low reset
//  START      in   1  alarm-match level from the alarm block; high for the whole matching minute
//  ALR_ONOFF  in   1  alarm armed (1) / disarmed (0)
//  SW_STOP    in   1  stop button, raw level, active-high
//  PIEZO      out  1  square-wave drive to the piezo
//  PLAYING    out  1  high while in TONE or GAP
//  NOTE_IDX   out  4  index of the current note, 0..MEL_LEN-1
// BEHAVIOUR
//  - Reset (RESETN=0, async): state=IDLE, PIEZO=0, PLAYING=0, NOTE_IDX=0, all counters 0, edge registers 0, ACKED=0.
//  - Edge detect: START and SW_STOP each pass one register (x_LAST); x_EN = x & ~x_LAST is registered.
//    A rising input is therefore acted on at the 2nd CLK edge after it goes high.
//  - States: IDLE, TONE, GAP, HOLD.
//    - IDLE->TONE on START_EN & ALR_ONOFF & ~ACKED; NOTE_IDX=0, duration counter cleared.
//    - TONE->GAP when the duration counter reaches NOTE_TICKS-1; PIEZO forced 0.
//    - GAP->TONE when the counter reaches GAP_TICKS-1. NOTE_IDX advances, wrapping from MEL_LEN-1 to 0, so the melody loops.
//    - TONE/GAP->HOLD on SW_STOP_EN; sets ACKED=1.
//    - Any state->IDLE when START=0 (level) or ALR_ONOFF=0. This clears ACKED, PIEZO=0 the next cycle.
//    - HOLD: silent until START falls (->IDLE). ACKED blocks a re-trigger within the same match minute.
//  - Priority (same cycle): reset > ALR_ONOFF=0 > START=0 > SW_STOP_EN > timer expiry.
//  - Tone: a half-period counter toggles PIEZO when count == HALF[NOTE_IDX]-1, then reloads 0.
//    The counter is cleared on every note change and on entering TONE, so each note starts with PIEZO=0.
//    HALF=0 is a rest: PIEZO held 0 while PLAYING stays 1.
//  - Widths: duration counter $clog2(max(NOTE_TICKS,GAP_TICKS)) bits; half-period counter 16 bits; table entries 16-bit unsigned.
//  - START rising again while already in TONE/GAP is ignored: no restart.
// CONFIGURATION
//  ALARM_SNOOZE_EN defined:
//    - Adds state SNOOZE. TONE/GAP->SNOOZE on SW_STOP_EN instead of HOLD.
//    - After SNOOZE_TICKS (pkg constant) silent cycles -> TONE with NOTE_IDX=0.
//    - Second STOP while in SNOOZE -> HOLD.
//    - START=0 / ALR_ONOFF=0 still force IDLE.
//  ALARM_SNOOZE_EN undefined: no SNOOZE state; STOP always -> HOLD.
// STRUCTURE
//  alarm_pkg contents:
//    - state encoding constants (IDLE=0, TONE=1, GAP=2, HOLD=3, SNOOZE=4)
//    - MEL_HALF[0:15] half-period table
//    - SNOOZE_TICKS
//  Sub-module tone_gen(RESETN, CLK, CLR, HALF[15:0], WAVE): divider only; alarm_melody owns the FSM and note timing.
// TESTING  (bench params NOTE_TICKS=16, GAP_TICKS=4, MEL_LEN=4, MEL_HALF={3,2,0,5}, SNOOZE_TICKS=20)
//  - ALR_ONOFF=1, raise START at cycle 10 -> PLAYING=1 at cycle 12; PIEZO toggles every 3 cycles; GAP after 16 cycles.
//    Then NOTE_IDX=1 with period 4. NOTE_IDX=2 holds PIEZO=0 with PLAYING=1.
//    Loops 3->0.
//  - Hold START through 3 loops, then drop it -> next cycle IDLE; PLAYING=0, PIEZO=0.
//  - STOP pulse mid-TONE (no ALARM_SNOOZE_EN) -> HOLD, silent. Pulse START low 1 cycle then high -> replays from NOTE_IDX=0.
//    STOP with START kept high -> never replays.
//  - ALR_ONOFF=0 and SW_STOP_EN in the same cycle -> IDLE (not HOLD); ACKED=0.
//  - RESETN low mid-GAP -> all outputs 0 immediately (async, before next CLK edge).
//  - With ALARM_SNOOZE_EN: STOP -> silent 20 cycles -> TONE at NOTE_IDX=0. Second STOP inside the snooze -> HOLD.

Source files
------------

// File: rtl/alarm_pkg.sv
// ============================================================================
// Module      : alarm_pkg
// Description : Shared state encoding, melody half-period table and snooze
//               length for the alarm melody player (ALARM_SNOOZE_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TONE   = 3'd1,
        ST_GAP    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_SNOOZE = 3'd4
    } state_t;

    // Half-period of each note in CLK cycles; 0 marks a rest.
    localparam logic [0:15][15:0] MEL_HALF = {
        16'd47801, 16'd37936, 16'd31888, 16'd23889,
        16'd0,     16'd23889, 16'd31888, 16'd37936,
        16'd47801, 16'd0,     16'd31888, 16'd31888,
        16'd37936, 16'd42589, 16'd47801, 16'd0
    };

    localparam int SNOOZE_TICKS = 1000000;

endpackage

`default_nettype wire

// File: rtl/tone_gen.sv
// ============================================================================
// Module      : tone_gen
// Description : Half-period divider producing the square wave for one note.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_gen (
    input  logic        RESETN,
    input  logic        CLK,
    input  logic        CLR,
    input  logic [15:0] HALF,
    output logic        WAVE
);

    logic [15:0] r_cnt;
    logic        r_wave;

    // A zero half-period is a rest: the wave stays low.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (CLR || (HALF == 16'd0)) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (r_cnt == (HALF - 16'd1)) begin
            r_cnt  <= '0;
            r_wave <= ~r_wave;
        end else begin
            r_cnt  <= r_cnt + 16'd1;
        end
    end

    assign WAVE = r_wave;

endmodule

`default_nettype wire

// File: rtl/alarm_melody.sv
// ============================================================================
// Module      : alarm_melody
// Description : Plays a looping melody on the piezo while the alarm matches.
//               Optional snooze on STOP when ALARM_SNOOZE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_melody
    import alarm_pkg::*;
#(
    parameter int               NOTE_TICKS = 50000,
    parameter int               GAP_TICKS  = 10000,
    parameter int               MEL_LEN    = 8,
`ifdef ALARM_SNOOZE_EN
    parameter int               SNOOZE_LEN = SNOOZE_TICKS,
`endif
    parameter logic [0:15][15:0] HALF_TAB  = MEL_HALF
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       START,
    input  logic       ALR_ONOFF,
    input  logic       SW_STOP,
    output logic       PIEZO,
    output logic       PLAYING,
    output logic [3:0] NOTE_IDX
);

    localparam int DUR_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
    localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_TICKS - 1);
    localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_TICKS - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(MEL_LEN - 1);
`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W = (SNOOZE_LEN > 1) ? $clog2(SNOOZE_LEN) : 1;
    localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'(SNOOZE_LEN - 1);
`endif

    state_t           r_state, w_state_nxt;
    logic             r_start_last, r_start_en;
    logic             r_stop_last, r_stop_en;
    logic             r_acked, w_acked_nxt;
    logic [DUR_W-1:0] r_dur, w_dur_nxt;
    logic [3:0]       r_note_idx, w_note_idx_nxt;
    logic             w_tone_clr;
    logic             w_wave;
`ifdef ALARM_SNOOZE_EN
    logic [SNZ_W-1:0] r_snz, w_snz_nxt;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_start_last <= 1'b0;
            r_start_en   <= 1'b0;
            r_stop_last  <= 1'b0;
            r_stop_en    <= 1'b0;
        end else begin
            r_start_last <= START;
            r_start_en   <= START & ~r_start_last;
            r_stop_last  <= SW_STOP;
            r_stop_en    <= SW_STOP & ~r_stop_last;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state    <= ST_IDLE;
            r_dur      <= '0;
            r_note_idx <= '0;
            r_acked    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            r_snz      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_dur      <= w_dur_nxt;
            r_note_idx <= w_note_idx_nxt;
            r_acked    <= w_acked_nxt;
`ifdef ALARM_SNOOZE_EN
            r_snz      <= w_snz_nxt;
`endif
        end
    end

    // Disarm and end-of-minute outrank STOP, which outranks note timing.
    always_comb begin
        w_state_nxt    = r_state;
        w_dur_nxt      = r_dur;
        w_note_idx_nxt = r_note_idx;
        w_acked_nxt    = r_acked;
`ifdef ALARM_SNOOZE_EN
        w_snz_nxt      = r_snz;
`endif
        if (!ALR_ONOFF || !START) begin
            w_state_nxt = ST_IDLE;
            w_acked_nxt = 1'b0;
            w_dur_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_start_en && !r_acked) begin
                        w_state_nxt    = ST_TONE;
                        w_note_idx_nxt = '0;
                        w_dur_nxt      = '0;
                    end
                end
                ST_TONE, ST_GAP: begin
                    if (r_stop_en) begin
                        w_dur_nxt = '0;
`ifdef ALARM_SNOOZE_EN
                        w_state_nxt = ST_SNOOZE;
                        w_snz_nxt   = '0;
`else
                        w_state_nxt = ST_HOLD;
                        w_acked_nxt = 1'b1;
`endif
                    end else if (r_state == ST_TONE) begin
                        if (r_dur == NOTE_LAST) begin
                            w_state_nxt = ST_GAP;
                            w_dur_nxt   = '0;
                        end else begin
                            w_dur_nxt   = r_dur + DUR_W'(1);
                        end
                    end else begin
                        if (r_dur == GAP_LAST) begin
                            w_state_nxt    = ST_TONE;
                            w_dur_nxt      = '0;
                            w_note_idx_nxt = (r_note_idx == IDX_LAST) ? 4'd0 : r_note_idx + 4'd1;
                        end else begin
                            w_dur_nxt      = r_dur + DUR_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    w_state_nxt = ST_HOLD;
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (r_stop_en) begin
                        w_state_nxt = ST_HOLD;
                        w_acked_nxt = 1'b1;
                    end else if (r_snz == SNZ_LAST) begin
                        w_state_nxt    = ST_TONE;
                        w_note_idx_nxt = '0;
                        w_dur_nxt      = '0;
                    end else begin
                        w_snz_nxt      = r_snz + SNZ_W'(1);
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Clearing on both the entry and exit edge makes every note start low
    // and silences the piezo in the same edge that leaves TONE.
    assign w_tone_clr = (r_state != ST_TONE) || (w_state_nxt != ST_TONE);

    tone_gen u_tone_gen (
        .RESETN (RESETN),
        .CLK    (CLK),
        .CLR    (w_tone_clr),
        .HALF   (HALF_TAB[r_note_idx]),
        .WAVE   (w_wave)
    );

    assign PIEZO    = w_wave;
    assign PLAYING  = (r_state == ST_TONE) || (r_state == ST_GAP);
    assign NOTE_IDX = r_note_idx;

endmodule

`default_nettype wire

// File: tb/tb_alarm_melody.sv
// ============================================================================
// Module      : tb_alarm_melody
// Description : Randomized and directed bench for alarm_melody against a
//               timeline model (ALARM_SNOOZE_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_melody;

    localparam int NT = 16;
    localparam int GT = 4;
    localparam int ML = 4;
    localparam int NOTE_PERIOD = NT + GT;
    localparam int LOOP = ML * NOTE_PERIOD;
`ifdef ALARM_SNOOZE_EN
    localparam int SNZ = 20;
`endif

    int halfs [4] = '{3, 2, 0, 5};

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       START = 1'b0;
    logic       ALR_ONOFF = 1'b0;
    logic       SW_STOP = 1'b0;
    logic       PIEZO;
    logic       PLAYING;
    logic [3:0] NOTE_IDX;

    alarm_melody #(
        .NOTE_TICKS (NT),
        .GAP_TICKS  (GT),
        .MEL_LEN    (ML),
`ifdef ALARM_SNOOZE_EN
        .SNOOZE_LEN (SNZ),
`endif
        .HALF_TAB   ({16'd3, 16'd2, 16'd0, 16'd5, {12{16'd0}}})
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .START     (START),
        .ALR_ONOFF (ALR_ONOFF),
        .SW_STOP   (SW_STOP),
        .PIEZO     (PIEZO),
        .PLAYING   (PLAYING),
        .NOTE_IDX  (NOTE_IDX)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    // Model: 0 idle, 1 playing, 2 hold, 3 snooze; m_t = cycles since play began
    int m_mode = 0;
    int m_t = 0;
    int m_snz = 0;
    bit m_acked = 1'b0;
    bit hs1 = 1'b0, hs2 = 1'b0, hp1 = 1'b0, hp2 = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_snz = 0; m_acked = 1'b0;
        hs1 = 1'b0; hs2 = 1'b0; hp1 = 1'b0; hp2 = 1'b0;
    endtask

    task automatic model_edge();
        bit en_s, en_p;
        en_s = hs1 & ~hs2;
        en_p = hp1 & ~hp2;
        if (!ALR_ONOFF || !START) begin
            m_mode = 0;
            m_acked = 1'b0;
        end else begin
            case (m_mode)
                0: if (en_s && !m_acked) begin m_mode = 1; m_t = 0; end
                1: begin
                    if (en_p) begin
`ifdef ALARM_SNOOZE_EN
                        m_mode = 3; m_snz = 0;
`else
                        m_mode = 2; m_acked = 1'b1;
`endif
                    end else begin
                        m_t++;
                    end
                end
                3: begin
`ifdef ALARM_SNOOZE_EN
                    if (en_p) begin m_mode = 2; m_acked = 1'b1; end
                    else if (m_snz == SNZ - 1) begin m_mode = 1; m_t = 0; end
                    else m_snz++;
`endif
                end
                default: ;
            endcase
        end
        hs2 = hs1; hs1 = START;
        hp2 = hp1; hp1 = SW_STOP;
    endtask

    task automatic check_outputs();
        int pos, note, off, h, e_piezo;
        if (m_mode == 1) begin
            pos  = m_t % LOOP;
            note = pos / NOTE_PERIOD;
            off  = pos % NOTE_PERIOD;
            h    = halfs[note];
            e_piezo = (off < NT && h != 0) ? ((off / h) % 2) : 0;
            chk("playing", int'(PLAYING), 1);
            chk("note_idx", int'(NOTE_IDX), note);
            chk("piezo", int'(PIEZO), e_piezo);
        end else begin
            chk("playing", int'(PLAYING), 0);
            chk("piezo", int'(PIEZO), 0);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        if (!RESETN) model_reset();
        else model_edge();
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic stop_pulse();
        SW_STOP = 1'b1; step();
        SW_STOP = 1'b0;
    endtask

    initial begin
        int guard;
        // Reset state
        steps(3);
        chk("rst_note_idx", int'(NOTE_IDX), 0);
        RESETN = 1'b1;
        ALR_ONOFF = 1'b1;
        steps(6);

        // Melody through three loops, then the match minute ends
        START = 1'b1;
        steps(2 + 3 * LOOP);
        START = 1'b0;
        step();
        chk("end_playing", int'(PLAYING), 0);
        steps(3);

        // STOP mid-tone, brief START drop replays, STOP with START held
        START = 1'b1;
        steps(8);
        stop_pulse();
        steps(30);
        START = 1'b0; step();
        START = 1'b1;
        steps(40);
        stop_pulse();
        steps(120);
`ifdef ALARM_SNOOZE_EN
        steps(30);
        stop_pulse();
        steps(5);
        stop_pulse();
        steps(40);
`endif

        // Disarm coinciding with the registered STOP edge
        START = 1'b0; step();
        START = 1'b1;
        steps(25);
        SW_STOP = 1'b1; step();
        SW_STOP = 1'b0; ALR_ONOFF = 1'b0; step();
        chk("disarm_playing", int'(PLAYING), 0);
        ALR_ONOFF = 1'b1;
        steps(5);
        START = 1'b0; step();
        START = 1'b1;
        steps(10);

        // Asynchronous reset in the middle of a gap of a non-zero note
        START = 1'b0; step();
        START = 1'b1;
        guard = 0;
        while (!(m_mode == 1 && (((m_t % LOOP) / NOTE_PERIOD) % 2) == 1 &&
                 (m_t % NOTE_PERIOD) >= NT + 1) && guard < 400) begin
            step();
            guard++;
        end
        chk("gap_reached", int'(guard < 400), 1);
        chk("gap_note_idx_nonzero", int'(NOTE_IDX != 4'd0), 1);
        #2;
        RESETN = 1'b0;
        #1;
        chk("async_playing", int'(PLAYING), 0);
        chk("async_piezo", int'(PIEZO), 0);
        chk("async_note_idx", int'(NOTE_IDX), 0);
        model_reset();
        steps(2);
        RESETN = 1'b1;
        steps(3);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) START = ~START;
            SW_STOP = ($urandom_range(0, 39) == 0);
            if (ALR_ONOFF) begin
                if ($urandom_range(0, 199) == 0) ALR_ONOFF = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                ALR_ONOFF = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
